// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse receive path: FSM states,
// symbol limits, ASCII codes and unit-based thresholds.
package morse_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MARK  = 2'd1,
        S_SPACE = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam int         MAX_ELEM      = 6;
    localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;
    localparam logic [7:0] ASCII_SPACE   = 8'h20;
    // Mark runs of at least DASH_FACTOR units are dashes; low runs of DASH_FACTOR
    // units end a character and WORD_FACTOR units end a word.
    localparam int         DASH_FACTOR   = 2;
    localparam int         WORD_FACTOR   = 5;

endpackage

// File: rtl/morse_code_rom.sv
// Combinational Morse lookup: element count plus right-aligned pattern
// (first element in the highest used bit, 1=dash) to ASCII; anything else is "?".
module morse_code_rom
    import morse_pkg::*;
(
    input  logic [2:0] i_len,
    input  logic [5:0] i_pat,
    output logic [7:0] o_char
);

    always_comb begin
        o_char = ASCII_UNKNOWN;
        case ({i_len, i_pat})
            9'b001_000000: o_char = "E";
            9'b001_000001: o_char = "T";
            9'b010_000000: o_char = "I";
            9'b010_000001: o_char = "A";
            9'b010_000010: o_char = "N";
            9'b010_000011: o_char = "M";
            9'b011_000000: o_char = "S";
            9'b011_000001: o_char = "U";
            9'b011_000010: o_char = "R";
            9'b011_000011: o_char = "W";
            9'b011_000100: o_char = "D";
            9'b011_000101: o_char = "K";
            9'b011_000110: o_char = "G";
            9'b011_000111: o_char = "O";
            9'b100_000000: o_char = "H";
            9'b100_000001: o_char = "V";
            9'b100_000010: o_char = "F";
            9'b100_000100: o_char = "L";
            9'b100_000110: o_char = "P";
            9'b100_000111: o_char = "J";
            9'b100_001000: o_char = "B";
            9'b100_001001: o_char = "X";
            9'b100_001010: o_char = "C";
            9'b100_001011: o_char = "Y";
            9'b100_001100: o_char = "Z";
            9'b100_001101: o_char = "Q";
            9'b101_000000: o_char = "5";
            9'b101_000001: o_char = "4";
            9'b101_000011: o_char = "3";
            9'b101_000111: o_char = "2";
            9'b101_001111: o_char = "1";
            9'b101_010000: o_char = "6";
            9'b101_011000: o_char = "7";
            9'b101_011100: o_char = "8";
            9'b101_011110: o_char = "9";
            9'b101_011111: o_char = "0";
            9'b110_010101: o_char = ".";
            default:       o_char = ASCII_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/morse_decoder.sv
// Morse receiver: run-length FSM, symbol shift register and a one-deep char holding register.
// Optional MORSE_DEC_WORDSPACE_EN also emits " " when a word gap is detected.
module morse_decoder
    import morse_pkg::*;
#(
    parameter int UNIT  = 1,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in,
    output logic [7:0] char_out,
    output logic       char_valid,
    input  logic       char_ready,
    output logic       ovf
);

    // Handshake: char_out is offered while char_valid=1 and is consumed on a rising edge
    // where char_valid & char_ready; it stays stable until then.
    localparam logic [CNT_W-1:0] DASH_TH = CNT_W'(DASH_FACTOR * UNIT);
    localparam logic [CNT_W-1:0] WORD_TH = CNT_W'(WORD_FACTOR * UNIT);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [2:0]       r_len, w_len_nxt;
    logic [5:0]       r_pat, w_pat_nxt;
    logic             r_sym_ovf, w_sym_ovf_nxt;
    logic [7:0]       r_char;
    logic             r_valid, r_ovf;
    logic             w_emit;
    logic [7:0]       w_emit_char, w_rom_char, w_sym_char;

    morse_code_rom u_rom (
        .i_len  (r_len),
        .i_pat  (r_pat),
        .o_char (w_rom_char)
    );

    assign w_sym_char = r_sym_ovf ? ASCII_UNKNOWN : w_rom_char;
    assign w_cnt_inc  = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_len_nxt     = r_len;
        w_pat_nxt     = r_pat;
        w_sym_ovf_nxt = r_sym_ovf;
        w_emit        = 1'b0;
        w_emit_char   = w_sym_char;
        case (r_state)
            S_IDLE: begin
                if (in) begin
                    w_state_nxt = S_MARK;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            S_MARK: begin
                if (in) begin
                    w_cnt_nxt = w_cnt_inc;
                end else begin
                    if (r_len == 3'(MAX_ELEM)) begin
                        w_sym_ovf_nxt = 1'b1;
                    end else begin
                        w_len_nxt = r_len + 3'd1;
                        w_pat_nxt = {r_pat[4:0], (r_cnt >= DASH_TH)};
                    end
                    w_state_nxt = S_SPACE;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            S_SPACE: begin
                if (in) begin
                    w_state_nxt = S_MARK;
                    w_cnt_nxt   = CNT_W'(1);
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc >= DASH_TH) begin
                        w_emit        = 1'b1;
                        w_len_nxt     = 3'd0;
                        w_pat_nxt     = 6'd0;
                        w_sym_ovf_nxt = 1'b0;
                        w_state_nxt   = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (in) begin
                    w_state_nxt = S_MARK;
                    w_cnt_nxt   = CNT_W'(1);
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc >= WORD_TH) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
`ifdef MORSE_DEC_WORDSPACE_EN
                        w_emit      = 1'b1;
                        w_emit_char = ASCII_SPACE;
`endif
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_len     <= 3'd0;
            r_pat     <= 6'd0;
            r_sym_ovf <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_len     <= w_len_nxt;
            r_pat     <= w_pat_nxt;
            r_sym_ovf <= w_sym_ovf_nxt;
        end
    end

    // An emit that coincides with acceptance reloads the register instead of dropping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_char  <= 8'h00;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_emit) begin
            if (r_valid && !char_ready) begin
                r_ovf <= 1'b1;
            end else begin
                r_char  <= w_emit_char;
                r_valid <= 1'b1;
            end
        end else if (r_valid && char_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign char_out   = r_char;
    assign char_valid = r_valid;
    assign ovf        = r_ovf;

endmodule
